// File: rtl/selftrigger_scheduler_pkg.sv
// Shared constants and state encoding for the self-trigger scheduler.
package selftrigger_scheduler_pkg;

    localparam int NCH_DEF  = 8;    // default number of self-trigger channels
    localparam int TS_W_DEF = 64;   // default timestamp width
    localparam int DT_W     = 16;   // dead-time counter / drop counter width

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/trigger_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or after
// rr_ptr, wrapping modulo NCH.
module trigger_rr_pick
    import selftrigger_scheduler_pkg::*;
#(
    parameter  int NCH  = NCH_DEF,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  pending,
    input  logic [CH_W-1:0] rr_ptr,
    output logic            found,
    output logic [CH_W-1:0] index
);

    logic [CH_W-1:0] w_idx;

    // Scan from farthest to nearest offset so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        w_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = rr_ptr + CH_W'(k);
            if (pending[w_idx]) begin
                found = 1'b1;
                index = w_idx;
            end
        end
    end

endmodule

// File: rtl/selftrigger_scheduler.sv
// Self-trigger scheduler: captures per-channel trigger edges with their
// timestamps and presents them one at a time, round-robin, to the readout.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no record presented; pick next pending channel if any
// ST_PRESENT | record held on rd_* until rd_valid & rd_ready
module selftrigger_scheduler
    import selftrigger_scheduler_pkg::*;
#(
    parameter  int NCH  = NCH_DEF,
    parameter  int TS_W = TS_W_DEF,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [NCH-1:0]  trig_in,
    input  logic [NCH-1:0]  chan_mask,
    input  logic [TS_W-1:0] timestamp,
    input  logic [DT_W-1:0] deadtime,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [CH_W-1:0] rd_channel,
    output logic [TS_W-1:0] rd_timestamp,
    output logic [NCH-1:0]  ch_busy,
    output logic [DT_W-1:0] drop_count
);

    sched_state_t    r_state, w_state_nxt;
    logic [NCH-1:0]  r_trig_q, r_arm, r_pending, w_pending_nxt;
    logic [TS_W-1:0] r_ts [NCH];
    logic [DT_W-1:0] r_dead [NCH];
    logic [CH_W-1:0] r_rr_ptr, r_rd_channel;
    logic [TS_W-1:0] r_rd_ts;
    logic [DT_W-1:0] r_drop_count;
    logic [DT_W:0]   w_drop_sum;
    logic [NCH-1:0]  w_edge, w_dead_nz, w_capture, w_drop, w_pick_req;
    logic            w_found, w_hs;
    logic [CH_W-1:0] w_pick_idx;

    // r_arm keeps a channel that was already high out of reset from
    // producing an edge until it has been seen low once.
    assign w_edge     = trig_in & ~r_trig_q & r_arm;
    assign w_hs       = (r_state == ST_PRESENT) && rd_ready;
    assign w_capture  = w_edge & chan_mask & {NCH{enable}} & ~r_pending & ~w_dead_nz;
    assign w_drop     = w_edge & chan_mask & {NCH{enable}} & (r_pending | w_dead_nz);
    assign w_pick_req = r_pending & chan_mask;

    assign rd_valid     = (r_state == ST_PRESENT);
    assign rd_channel   = r_rd_channel;
    assign rd_timestamp = r_rd_ts;
    assign ch_busy      = r_pending | w_dead_nz;
    assign drop_count   = r_drop_count;

    trigger_rr_pick #(.NCH(NCH)) u_pick (
        .pending (w_pick_req),
        .rr_ptr  (r_rr_ptr),
        .found   (w_found),
        .index   (w_pick_idx)
    );

    // Per-channel dead-time activity flags.
    always_comb begin
        w_dead_nz = '0;
        for (int i = 0; i < NCH; i++) w_dead_nz[i] = |r_dead[i];
    end

    // Pending update: capture, mask clear (presented record exempt), handshake clear.
    always_comb begin
        w_pending_nxt = r_pending | w_capture;
        for (int i = 0; i < NCH; i++) begin
            if (!chan_mask[i] && !(rd_valid && (r_rd_channel == CH_W'(i))))
                w_pending_nxt[i] = 1'b0;
        end
        if (w_hs) w_pending_nxt[r_rd_channel] = 1'b0;
    end

    // Add one per dropping channel, clipping at all-ones.
    always_comb begin
        w_drop_sum = {1'b0, r_drop_count};
        for (int i = 0; i < NCH; i++) w_drop_sum = w_drop_sum + (DT_W + 1)'(w_drop[i]);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_found)  w_state_nxt = ST_PRESENT;
            ST_PRESENT: if (rd_ready) w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, presented record and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rd_channel <= '0;
            r_rd_ts      <= '0;
            r_rr_ptr     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_found) begin
                r_rd_channel <= w_pick_idx;
                r_rd_ts      <= r_ts[w_pick_idx];
            end
            if (w_hs) r_rr_ptr <= r_rd_channel + CH_W'(1);
        end
    end

    // Per-channel trigger history, pending flags, timestamps and dead timers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig_q  <= '0;
            r_arm     <= '0;
            r_pending <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_ts[i]   <= '0;
                r_dead[i] <= '0;
            end
        end else begin
            r_trig_q  <= trig_in;
            r_arm     <= r_arm | ~trig_in;
            r_pending <= w_pending_nxt;
            for (int i = 0; i < NCH; i++) begin
                if (w_capture[i]) r_ts[i] <= timestamp;
                if (w_hs && (r_rd_channel == CH_W'(i)))
                    r_dead[i] <= deadtime;
                else if (w_dead_nz[i])
                    r_dead[i] <= r_dead[i] - DT_W'(1);
            end
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_drop_count <= '0;
        else if (w_drop_sum[DT_W])
            r_drop_count <= '1;
        else
            r_drop_count <= w_drop_sum[DT_W-1:0];
    end

endmodule

// File: tb/tb_selftrigger_scheduler.sv
// Directed bench for selftrigger_scheduler. Inputs change and outputs are
// sampled on the falling edge; a posedge monitor logs completed handshakes.
module tb_selftrigger_scheduler;

    logic        clk = 1'b0;
    logic        reset, enable, rd_ready, rd_valid;
    logic [7:0]  trig_in, chan_mask, ch_busy;
    logic [63:0] timestamp, rd_timestamp;
    logic [15:0] deadtime, drop_count;
    logic [2:0]  rd_channel;

    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;
    int     rec_ch[$];
    longint rec_ts[$];
    longint rec_cyc[$];

    selftrigger_scheduler #(.NCH(8), .TS_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .trig_in      (trig_in),
        .chan_mask    (chan_mask),
        .timestamp    (timestamp),
        .deadtime     (deadtime),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_channel   (rd_channel),
        .rd_timestamp (rd_timestamp),
        .ch_busy      (ch_busy),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && rd_valid && rd_ready) begin
            rec_ch.push_back(int'(rd_channel));
            rec_ts.push_back(longint'(rd_timestamp));
            rec_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        timestamp = timestamp + 1;
    endtask

    task automatic clear_recs();
        rec_ch.delete();
        rec_ts.delete();
        rec_cyc.delete();
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        enable    = 1'b1;
        trig_in   = '0;
        chan_mask = 8'hFF;
        deadtime  = '0;
        rd_ready  = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        clear_recs();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; trig_in = '0; chan_mask = 8'hFF;
        timestamp = '0; deadtime = '0; rd_ready = 1'b0;
        repeat (2) tick();
        check_val("rst_valid", rd_valid, 1'b0);
        check_val("rst_chan", rd_channel, 3'd0);
        check_val("rst_ts", rd_timestamp, 64'd0);
        check_val("rst_busy", ch_busy, 8'h00);
        check_val("rst_drop", drop_count, 16'd0);

        // Single channel-3 pulse, 4 cycles wide.
        reset_dut(); rd_ready = 1'b1;
        tick(); trig_in = 8'h08; timestamp = 64'd1000;
        tick(); check_val("c3_lat1_valid", rd_valid, 1'b0);
        tick();
        check_val("c3_valid", rd_valid, 1'b1);
        check_val("c3_chan", rd_channel, 3'd3);
        check_val("c3_ts", rd_timestamp, 64'd1000);
        tick(); check_val("c3_valid_drop", rd_valid, 1'b0);
        tick(); trig_in = 8'h00;
        repeat (4) tick();
        check_val("c3_nrec", rec_ch.size(), 1);
        check_val("c3_nodrop", drop_count, 16'd0);

        // Simultaneous 0,2,5 -> round-robin order, 2-cycle spacing.
        reset_dut(); rd_ready = 1'b1;
        tick(); trig_in = 8'b0010_0101;
        tick(); trig_in = 8'h00;
        repeat (8) tick();
        check_val("rr_nrec", rec_ch.size(), 3);
        if (rec_ch.size() == 3) begin
            check_val("rr_ch0", rec_ch[0], 0);
            check_val("rr_ch1", rec_ch[1], 2);
            check_val("rr_ch2", rec_ch[2], 5);
            check_val("rr_gap1", rec_cyc[1] - rec_cyc[0], 2);
            check_val("rr_gap2", rec_cyc[2] - rec_cyc[1], 2);
        end

        // Dead time 10 on channel 1: re-trigger at +5 dropped, at +12 accepted.
        reset_dut(); rd_ready = 1'b1; deadtime = 16'd10;
        tick(); trig_in = 8'h02;
        tick(); trig_in = 8'h00;
        tick(); check_val("dt_first_valid", rd_valid, 1'b1);
        tick(); check_val("dt_busy_dead", ch_busy, 8'h02);
        repeat (3) tick();
        tick(); trig_in = 8'h02;
        tick(); trig_in = 8'h00;
        check_val("dt_drop1", drop_count, 16'd1);
        check_val("dt_no_valid", rd_valid, 1'b0);
        repeat (5) tick();
        check_val("dt_busy_clear", ch_busy, 8'h00);
        tick(); trig_in = 8'h02;
        tick(); trig_in = 8'h00;
        tick(); check_val("dt_second_valid", rd_valid, 1'b1);
        tick();
        check_val("dt_nrec", rec_ch.size(), 2);
        check_val("dt_drop_final", drop_count, 16'd1);

        // Backpressure 20 cycles on channel 4, three edges dropped meanwhile.
        reset_dut();
        tick(); trig_in = 8'h10; timestamp = 64'd500;
        tick(); trig_in = 8'h00;
        tick();
        for (int i = 0; i < 20; i++) begin
            check_val("bp_valid", rd_valid, 1'b1);
            check_val("bp_chan", rd_channel, 3'd4);
            check_val("bp_ts", rd_timestamp, 64'd500);
            trig_in = (i == 2 || i == 6 || i == 10) ? 8'h10 : 8'h00;
            tick();
        end
        check_val("bp_drops", drop_count, 16'd3);
        check_val("bp_valid_end", rd_valid, 1'b1);
        rd_ready = 1'b1;
        tick();
        check_val("bp_released", rd_valid, 1'b0);
        check_val("bp_nrec", rec_ch.size(), 1);
        if (rec_ts.size() == 1) check_val("bp_rec_ts", rec_ts[0], 500);

        // Reset during PRESENT with channel 6 held high.
        reset_dut();
        tick(); trig_in = 8'h40;
        tick(); trig_in = 8'hC0;
        tick(); trig_in = 8'h40;
        check_val("rp_valid", rd_valid, 1'b1);
        check_val("rp_chan", rd_channel, 3'd6);
        tick(); trig_in = 8'hC0;
        tick(); trig_in = 8'h40;
        check_val("rp_drop_pre", drop_count, 16'd1);
        check_val("rp_busy_pre", ch_busy, 8'hC0);
        reset = 1'b1;
        #1;
        check_val("rp_valid0", rd_valid, 1'b0);
        check_val("rp_chan0", rd_channel, 3'd0);
        check_val("rp_ts0", rd_timestamp, 64'd0);
        check_val("rp_busy0", ch_busy, 8'h00);
        check_val("rp_drop0", drop_count, 16'd0);
        tick(); tick(); reset = 1'b0; rd_ready = 1'b1;
        repeat (5) tick();
        check_val("rp_held_valid", rd_valid, 1'b0);
        check_val("rp_held_busy", ch_busy, 8'h00);
        tick(); trig_in = 8'h00;
        tick(); trig_in = 8'h40;
        tick(); tick();
        check_val("rp_rearm_valid", rd_valid, 1'b1);
        check_val("rp_rearm_chan", rd_channel, 3'd6);
        tick();
        check_val("rp_nrec", rec_ch.size(), 1);
        trig_in = 8'h00;

        // Enable / mask gating and mask clear while presenting.
        reset_dut(); enable = 1'b0;
        tick(); trig_in = 8'h04;
        tick(); trig_in = 8'h00;
        tick(); check_val("en_gate_busy", ch_busy, 8'h00);
        enable = 1'b1; chan_mask = 8'hFB;
        tick(); trig_in = 8'h04;
        tick(); trig_in = 8'h00;
        tick();
        check_val("mask_gate_busy", ch_busy, 8'h00);
        check_val("mask_gate_drop", drop_count, 16'd0);
        chan_mask = 8'hFF;
        tick(); trig_in = 8'h0C;
        tick(); trig_in = 8'h00;
        tick();
        check_val("mc_valid", rd_valid, 1'b1);
        check_val("mc_chan", rd_channel, 3'd2);
        chan_mask = 8'hF3;
        tick();
        check_val("mc_busy", ch_busy, 8'h04);
        check_val("mc_still_valid", rd_valid, 1'b1);
        rd_ready = 1'b1;
        tick();
        check_val("mc_done_valid", rd_valid, 1'b0);
        check_val("mc_done_busy", ch_busy, 8'h00);
        repeat (3) tick();
        check_val("mc_nrec", rec_ch.size(), 1);
        chan_mask = 8'hFF;

        // Drop counter saturation: 8 channels pending, 8 drops per pulse.
        reset_dut();
        tick(); trig_in = 8'hFF;
        tick(); trig_in = 8'h00;
        for (int p = 0; p < 8191; p++) begin
            tick(); trig_in = 8'hFF;
            tick(); trig_in = 8'h00;
        end
        tick(); check_val("sat_pre", drop_count, 16'hFFF8);
        trig_in = 8'hFF;
        tick(); trig_in = 8'h00;
        tick(); check_val("sat_hit", drop_count, 16'hFFFF);
        for (int p = 0; p < 600; p++) begin
            tick(); trig_in = 8'hFF;
            tick(); trig_in = 8'h00;
        end
        tick();
        check_val("sat_hold", drop_count, 16'hFFFF);
        check_val("sat_valid", rd_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
